add_8bit: RTL and testbench

- 8-bit two's-complement adder/subtractor with registered outputs: sum/difference, carry-out and signed-overflow flag.
- Used as a datapath arithmetic primitive; one-cycle latency from input sampling to result.
- Inputs are sampled on every rising clock edge; no handshake.

---
 rtl/add_8bit.sv | 65 ++++++
 tb/tb_add_8bit.sv | 108 ++++++++++
 2 files changed

// File: rtl/add_8bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | add_8bit : registered ripple-carry two's-complement adder/subtractor with  |
// |            carry-out and signed-overflow flags.                            |
// | Optional : ADD8_SAT_EN - saturate S to the signed limit on overflow.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module add_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             addsub,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ov_flag
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_s_next;
  logic             w_ov;

  // Carry-in of 1 on subtract completes the ~B + 1 negation.
  assign w_c[0] = addsub;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      logic w_bx;
      assign w_bx       = B[i] ^ addsub;
      assign w_sum[i]   = A[i] ^ w_bx ^ w_c[i];
      assign w_c[i+1]   = (A[i] & w_bx) | (A[i] & w_c[i]) | (w_bx & w_c[i]);
    end
  endgenerate

  assign w_ov = w_c[WIDTH] ^ w_c[WIDTH-1];

`ifdef ADD8_SAT_EN
  // On overflow the true result shares A's sign, so A's MSB picks the limit.
  always_comb begin
    w_s_next = w_sum;
    if (w_ov) begin
      w_s_next = A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_s_next = w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S       <= '0;
      cout    <= 1'b0;
      ov_flag <= 1'b0;
    end else begin
      S       <= w_s_next;
      cout    <= w_c[WIDTH];
      ov_flag <= w_ov;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_8bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_add_8bit : directed self-checking bench for add_8bit.                   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_add_8bit;

`ifdef ADD8_SAT_EN
  localparam bit c_sat = 1'b1;
`else
  localparam bit c_sat = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       addsub;
  logic [7:0] s;
  logic       cout;
  logic       ov_flag;

  int n_checks = 0;
  int n_pass   = 0;

  add_8bit #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (a),
    .B       (b),
    .addsub  (addsub),
    .S       (s),
    .cout    (cout),
    .ov_flag (ov_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic vec(input string tag, input logic [7:0] va, input logic [7:0] vb,
                     input logic vas, input logic [7:0] es_wrap, input logic [7:0] es_sat,
                     input logic ec, input logic ev);
    @(negedge clk);
    a = va; b = vb; addsub = vas;
    @(posedge clk); #1;
    chk({tag, ".S"}, s, c_sat ? es_sat : es_wrap);
    chk({tag, ".cout"}, {7'd0, cout}, {7'd0, ec});
    chk({tag, ".ov"}, {7'd0, ov_flag}, {7'd0, ev});
  endtask

  initial begin
    rst_n = 1'b0; a = 8'h00; b = 8'h00; addsub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.S", s, 8'h00);
    chk("rst.flags", {6'd0, cout, ov_flag}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    vec("add2+1",   8'd2,  8'd1,   1'b0, 8'd3,   8'd3,   1'b0, 1'b0);
    vec("add7+3",   8'd7,  8'd3,   1'b0, 8'd10,  8'd10,  1'b0, 1'b0);
    vec("add7+125", 8'd7,  8'd125, 1'b0, 8'h84,  8'h7F,  1'b0, 1'b1);
    vec("sub22-10", 8'd22, 8'd10,  1'b1, 8'd12,  8'd12,  1'b1, 1'b0);
    vec("sub22-26", 8'd22, 8'd26,  1'b1, 8'd252, 8'd252, 1'b0, 1'b0);
    vec("sub22-131",8'd22, 8'h83,  1'b1, 8'h93,  8'h7F,  1'b0, 1'b1);

    // Latency: new inputs must not show until the next rising edge.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; addsub = 1'b0;
    #1;
    chk("lat.hold.S", s, c_sat ? 8'h7F : 8'h93);
    chk("lat.hold.ov", {7'd0, ov_flag}, 8'h01);
    @(posedge clk); #1;
    chk("lat.S", s, 8'h00);
    chk("lat.cout", {7'd0, cout}, 8'h01);
    chk("lat.ov", {7'd0, ov_flag}, 8'h00);

    vec("sub0-1",   8'h00, 8'h01, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    vec("sub80-80", 8'h80, 8'h80, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    vec("sub0-80",  8'h00, 8'h80, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1);
    vec("add80+80", 8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1);
    vec("addFF+FF", 8'hFF, 8'hFF, 1'b0, 8'hFE, 8'hFE, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle, with nonzero outputs present.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.S", s, 8'h00);
    chk("arst.flags", {6'd0, cout, ov_flag}, 8'h00);
    @(posedge clk); #1;
    chk("arst.hold.S", s, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    vec("post.add", 8'd7, 8'd125, 1'b0, 8'h84, 8'h7F, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
